pq_arb: RTL and testbench

PQ_ARB -- requirements
Module: pq_arb

---
 rtl/pq_pkg.sv | 22 ++
 rtl/pq_rr_pick.sv | 35 +++
 rtl/pq_arb.sv | 143 ++++++++++++++
 tb/tb_pq_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types for the priority-queue arbiter: key-value record, idle constants, FSM states.
package pq_pkg;

    localparam int KEY_W = 8;
    localparam int VAL_W = 8;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } kv_t;

    localparam logic [KEY_W-1:0] KEY0 = '0;
    localparam logic [VAL_W-1:0] VAL0 = '0;
    localparam kv_t              KV0  = '{key: KEY0, val: VAL0};

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } pq_arb_state_t;

endpackage

// File: rtl/pq_rr_pick.sv
// Round-robin picker: first set bit of elig at or after rr_ptr, wrapping modulo NREQ.
module pq_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         elig,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] index
);

    localparam int IW = $clog2(NREQ);
    localparam int SW = IW + 1;

    logic [NREQ-1:0] rot;
    logic [SW-1:0]   sum;

    // Rotate so bit 0 is the requester at rr_ptr; lowest set bit then wins.
    assign rot = NREQ'({elig, elig} >> rr_ptr);

    always_comb begin
        valid = 1'b0;
        sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                sum   = {1'b0, rr_ptr} + SW'(k);
            end
        end
        if (sum >= SW'(NREQ)) begin
            sum = sum - SW'(NREQ);
        end
        index = sum[IW-1:0];
    end

endmodule

// File: rtl/pq_arb.sv
// Round-robin arbiter sharing one priority queue among NREQ requesters, with flush drain.
// Define PQ_ARB_STATS_EN to build the issued-operation counter behind op_cnt.
module pq_arb
    import pq_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_enq,
    input  logic [NREQ-1:0]         req_deq,
    input  kv_t  [NREQ-1:0]         req_kv,
    output logic [NREQ-1:0]         ack,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output kv_t                     rsp_kv,
    input  logic                    flush,
    output logic                    flush_done,
    output logic                    pq_enq,
    output logic                    pq_deq,
    output kv_t                     pq_kvi,
    input  kv_t                     pq_kvo,
    input  logic                    pq_full,
    input  logic                    pq_empty,
    input  logic                    pq_busy,
    output logic [31:0]             op_cnt,
    output logic [1:0]              dbg_state
);

    localparam int IW = $clog2(NREQ);

    pq_arb_state_t   state, state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   win;
    logic            win_valid;
    logic [NREQ-1:0] elig;
    logic            issue;
    logic            flush_deq;

    // A deq or replace needs a head entry; a pure enqueue needs room.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_deq[i] ? !pq_empty : (req_enq[i] && !pq_full);
        end
    end

    pq_rr_pick #(.NREQ(NREQ)) u_pick (
        .elig   (elig),
        .rr_ptr (rr_ptr),
        .valid  (win_valid),
        .index  (win)
    );

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        flush_deq  = 1'b0;
        flush_done = 1'b0;
        ack        = '0;
        pq_enq     = 1'b0;
        pq_deq     = 1'b0;
        pq_kvi     = KV0;
        case (state)
            ARB: begin
                if (pq_busy) begin
                    state_nxt = BUSY;
                end else if (win_valid) begin
                    issue     = 1'b1;
                    ack[win]  = 1'b1;
                    pq_enq    = req_enq[win];
                    pq_deq    = req_deq[win];
                    pq_kvi    = req_kv[win];
                end
                if (flush) begin
                    state_nxt = FLUSH;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_nxt = FLUSH;
                end else if (!pq_busy) begin
                    state_nxt = ARB;
                end
            end
            FLUSH: begin
                if (pq_empty) begin
                    flush_done = 1'b1;
                    state_nxt  = ARB;
                end else if (!pq_busy) begin
                    flush_deq = 1'b1;
                    pq_deq    = 1'b1;
                end
            end
            default: state_nxt = ARB;
        endcase
        // Nothing reaches the queue or the requesters while reset is held.
        if (rst) begin
            state_nxt  = ARB;
            issue      = 1'b0;
            flush_deq  = 1'b0;
            flush_done = 1'b0;
            ack        = '0;
            pq_enq     = 1'b0;
            pq_deq     = 1'b0;
            pq_kvi     = KV0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_kv    <= KV0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= issue && req_deq[win];
            if (issue) begin
                rr_ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
            if (issue && req_deq[win]) begin
                rsp_id <= win;
                rsp_kv <= pq_kvo;
            end
        end
    end

`ifdef PQ_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt <= '0;
        end else if (issue || flush_deq) begin
            op_cnt <= op_cnt + 32'd1;
        end
    end
`else
    assign op_cnt = '0;
`endif

    assign dbg_state = state;

endmodule

// File: tb/tb_pq_arb.sv
// Self-checking bench for pq_arb: directed scenarios plus randomized traffic against a reference model.
module tb_pq_arb;
    import pq_pkg::*;

    localparam int NREQ  = 4;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NREQ-1:0]  req_enq = '0;
    logic [NREQ-1:0]  req_deq = '0;
    kv_t  [NREQ-1:0]  req_kv = '0;
    logic [NREQ-1:0]  ack;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    kv_t              rsp_kv;
    logic             flush = 1'b0;
    logic             flush_done;
    logic             pq_enq;
    logic             pq_deq;
    kv_t              pq_kvi;
    kv_t              pq_kvo = KV0;
    logic             pq_full = 1'b0;
    logic             pq_empty = 1'b1;
    logic             pq_busy = 1'b0;
    logic [31:0]      op_cnt;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    pq_arb #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_enq    (req_enq),
        .req_deq    (req_deq),
        .req_kv     (req_kv),
        .ack        (ack),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_kv     (rsp_kv),
        .flush      (flush),
        .flush_done (flush_done),
        .pq_enq     (pq_enq),
        .pq_deq     (pq_deq),
        .pq_kvi     (pq_kvi),
        .pq_kvo     (pq_kvo),
        .pq_full    (pq_full),
        .pq_empty   (pq_empty),
        .pq_busy    (pq_busy),
        .op_cnt     (op_cnt),
        .dbg_state  (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_ops(input int n);
`ifdef PQ_ARB_STATS_EN
        return n;
`else
        return 0;
`endif
    endfunction

    // Priority-queue device: sorted list, smallest key at the head.
    kv_t dev_q[$];
    always @(posedge clk) begin
        int p;
        if (pq_deq && dev_q.size() > 0) dev_q.pop_front();
        if (pq_enq) begin
            p = 0;
            while (p < dev_q.size() && dev_q[p].key <= pq_kvi.key) p++;
            dev_q.insert(p, pq_kvi);
        end
        pq_kvo   <= (dev_q.size() > 0) ? dev_q[0] : KV0;
        pq_empty <= (dev_q.size() == 0);
        pq_full  <= (dev_q.size() >= DEPTH);
    end

    // Reference model, evaluated mid-cycle when inputs and queue flags are stable.
    bit            mon_en = 1'b0;
    pq_arb_state_t m_mode = ARB;
    int            m_rr = 0;
    int            m_ops = 0;
    logic [NREQ-1:0] m_ack_last = '0;
    logic [17:0]   exp_q[$];

    always @(negedge clk) begin
        logic [NREQ-1:0] e_ack;
        logic [NREQ-1:0] elig;
        logic            e_enq, e_deq, e_fd;
        kv_t             e_kvi;
        logic [17:0]     rsp_exp;
        int              w;
        if (mon_en) begin
            e_ack = '0; e_enq = 1'b0; e_deq = 1'b0; e_fd = 1'b0; e_kvi = KV0; w = -1;
            check("m_rsp_valid", rsp_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                rsp_exp = exp_q.pop_front();
                check("m_rsp_id_kv", {rsp_id, rsp_kv}, rsp_exp);
            end
            check("m_op_cnt", op_cnt, exp_ops(m_ops));
            check("m_state", dbg_state, m_mode);
            if (rst) begin
                m_mode = ARB; m_rr = 0; m_ops = 0;
            end else begin
                case (m_mode)
                    ARB: begin
                        if (!pq_busy) begin
                            for (int i = 0; i < NREQ; i++)
                                elig[i] = req_deq[i] ? !pq_empty : (req_enq[i] && !pq_full);
                            for (int k = 0; k < NREQ; k++)
                                if (w < 0 && elig[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
                        end
                        if (w >= 0) begin
                            e_ack[w] = 1'b1;
                            e_enq = req_enq[w];
                            e_deq = req_deq[w];
                            e_kvi = req_kv[w];
                            m_rr  = (w + 1) % NREQ;
                            m_ops++;
                            if (e_deq) exp_q.push_back({w[1:0], pq_kvo});
                        end
                        m_mode = flush ? FLUSH : (pq_busy ? BUSY : ARB);
                    end
                    BUSY: m_mode = flush ? FLUSH : (pq_busy ? BUSY : ARB);
                    default: begin
                        if (pq_empty) begin
                            e_fd = 1'b1;
                            m_mode = ARB;
                        end else if (!pq_busy) begin
                            e_deq = 1'b1;
                            m_ops++;
                        end
                    end
                endcase
            end
            check("m_ack", ack, e_ack);
            check("m_pq_enq", pq_enq, e_enq);
            check("m_pq_deq", pq_deq, e_deq);
            check("m_pq_kvi", pq_kvi, e_kvi);
            check("m_flush_done", flush_done, e_fd);
            m_ack_last = e_ack;
        end
    end

    // Advance one cycle; requesters drop whatever was acked.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (m_ack_last[i]) begin
                req_enq[i] = 1'b0;
                req_deq[i] = 1'b0;
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        int op;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_kv", rsp_kv, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_pq_enq", pq_enq, 0);
        check("rst_pq_deq", pq_deq, 0);
        check("rst_op_cnt", op_cnt, 0);
        check("rst_state", dbg_state, ARB);
        step();
        rst = 1'b0;

        // Four simultaneous enqueues granted in index order, then a deq returns the min.
        req_enq = 4'b1111;
        req_kv[0] = '{key: 8'd40, val: 8'h40};
        req_kv[1] = '{key: 8'd30, val: 8'h30};
        req_kv[2] = '{key: 8'd20, val: 8'h20};
        req_kv[3] = '{key: 8'd10, val: 8'h10};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("s1_ack_order", ack, 32'd1 << k);
            step();
        end
        req_deq[0] = 1'b1;
        @(negedge clk);
        check("s1_deq_ack", ack, 4'b0001);
        check("s1_op_cnt4", op_cnt, exp_ops(4));
        step();
        @(negedge clk);
        check("s1_rsp_valid", rsp_valid, 1);
        check("s1_rsp_key", rsp_kv.key, 10);
        check("s1_rsp_id", rsp_id, 0);
        check("s1_op_cnt5", op_cnt, exp_ops(5));

        // Flush three entries while a deq request waits.
        step();
        flush = 1'b1;
        @(negedge clk);
        check("s4_flush_cycle_ack", ack, 0);
        step();
        req_deq[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("s4_flush_deq", pq_deq, 1);
            check("s4_flush_noack", ack, 0);
            check("s4_flush_state", dbg_state, FLUSH);
            step();
        end
        @(negedge clk);
        check("s4_flush_done", flush_done, 1);
        check("s4_empty", pq_empty, 1);
        check("s4_no_extra_deq", pq_deq, 0);
        step();
        req_deq[3] = 1'b0;
        @(negedge clk);
        check("s4_done_pulse", flush_done, 0);
        check("s4_back_arb", dbg_state, ARB);
        check("s4_op_cnt", op_cnt, exp_ops(8));

        // Deq on an empty queue waits until an enqueue lands.
        step();
        req_deq[2] = 1'b1;
        @(negedge clk);
        check("s2_no_ack_a", ack, 0);
        step();
        @(negedge clk);
        check("s2_no_ack_b", ack, 0);
        step();
        req_enq[0] = 1'b1;
        req_kv[0] = '{key: 8'd5, val: 8'h55};
        @(negedge clk);
        check("s2_enq_ack", ack, 4'b0001);
        step();
        @(negedge clk);
        check("s2_deq_ack", ack, 4'b0100);
        step();
        @(negedge clk);
        check("s2_rsp_valid", rsp_valid, 1);
        check("s2_rsp_id", rsp_id, 2);
        check("s2_rsp_kv", rsp_kv, 16'h0555);

        // Replace: head 7 swapped for 3 in one op.
        step();
        req_enq[0] = 1'b1;
        req_kv[0] = '{key: 8'd7, val: 8'h77};
        @(negedge clk);
        check("s3_seed_ack", ack, 4'b0001);
        step();
        req_enq[1] = 1'b1;
        req_deq[1] = 1'b1;
        req_kv[1] = '{key: 8'd3, val: 8'h33};
        @(negedge clk);
        check("s3_rep_ack", ack, 4'b0010);
        check("s3_rep_enq", pq_enq, 1);
        check("s3_rep_deq", pq_deq, 1);
        check("s3_rep_kvi", pq_kvi, 16'h0333);
        step();
        @(negedge clk);
        check("s3_rsp_valid", rsp_valid, 1);
        check("s3_rsp_id", rsp_id, 1);
        check("s3_rsp_kv", rsp_kv, 16'h0777);
        check("s3_new_head", pq_kvo, 16'h0333);

        // Busy stall: nothing granted until busy falls, then rr order from ptr 2.
        step();
        pq_busy = 1'b1;
        req_enq = 4'b1101;
        req_kv[0] = '{key: 8'd50, val: 8'h50};
        req_kv[2] = '{key: 8'd52, val: 8'h52};
        req_kv[3] = '{key: 8'd53, val: 8'h53};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("s5_busy_noack", ack, 0);
            step();
        end
        pq_busy = 1'b0;
        @(negedge clk);
        check("s5_busy_exit_noack", ack, 0);
        check("s5_busy_state", dbg_state, BUSY);
        step();
        @(negedge clk);
        check("s5_rr_first", ack, 4'b0100);
        step();
        @(negedge clk);
        check("s5_rr_second", ack, 4'b1000);
        step();
        @(negedge clk);
        check("s5_rr_third", ack, 4'b0001);

        // Reset in the middle of a flush aborts it without flush_done.
        step();
        flush = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        check("s6_in_flush", dbg_state, FLUSH);
        check("s6_flush_deq", pq_deq, 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("s6_rst_no_done", flush_done, 0);
        check("s6_rst_no_deq", pq_deq, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("s6_state_arb", dbg_state, ARB);
        check("s6_op_cnt_zero", op_cnt, 0);
        check("s6_rsp_valid", rsp_valid, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            check("s6_no_late_done", flush_done, 0);
        end

        // Randomized traffic, all checked by the reference model.
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            pq_busy = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) flush = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_enq[i] && !req_deq[i] && $urandom_range(0, 2) == 0) begin
                    op = int'($urandom_range(1, 3));
                    req_enq[i] = op[0];
                    req_deq[i] = op[1];
                    req_kv[i] = 16'($urandom_range(0, 65535));
                end
            end
        end
        step();
        rst = 1'b0;
        pq_busy = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
